// File: rtl/can_rx_buffer_pkg.sv
// Shared CAN receive-path definitions: field widths and the stored frame record.
package can_defs;
  localparam int CAN_ID_W      = 11;
  localparam int CAN_MAX_BYTES = 8;

  typedef struct packed {
    logic [CAN_ID_W-1:0]           id;
    logic [3:0]                    dlc;
    logic [CAN_MAX_BYTES-1:0][7:0] data;
  } rx_frame_t;
endpackage

// File: rtl/can_rx_filter.sv
// Single code/mask acceptance filter for standard identifiers; mask bit 1 = don't care.
module can_rx_filter
  import can_defs::*;
(
  input  logic [CAN_ID_W-1:0] rx_id,
  input  logic [CAN_ID_W-1:0] acc_code,
  input  logic [CAN_ID_W-1:0] acc_mask,
  input  logic                filter_en,
  output logic                accept
);
  assign accept = !filter_en || (((rx_id ^ acc_code) & ~acc_mask) == '0);
endmodule

// File: rtl/can_rx_buffer.sv
// Filtered receive FIFO with registered first-word-fall-through head and overrun tracking.
module can_rx_buffer
  import can_defs::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [CAN_ID_W-1:0]            rx_id,
  input  logic [3:0]                     rx_dlc,
  input  logic [CAN_MAX_BYTES-1:0][7:0]  rx_data,
  input  logic                           filter_en,
  input  logic [CAN_ID_W-1:0]            acc_code,
  input  logic [CAN_ID_W-1:0]            acc_mask,
  input  logic                           re,
  input  logic                           overrun_clr,
  output logic                           out_valid,
  output logic [CAN_ID_W-1:0]            out_id,
  output logic [3:0]                     out_dlc,
  output logic [CAN_MAX_BYTES-1:0][7:0]  out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           overrun,
  output logic [DROP_W-1:0]              drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rx_frame_t             mem [DEPTH];
  rx_frame_t             in_frame;
  rx_frame_t             out_frame_reg;
  rx_frame_t             out_frame_next;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overrun_reg;
  logic [DROP_W-1:0]     drop_cnt_reg;
  logic                  accept, push, pop, overflow;

  can_rx_filter u_filter (
    .rx_id     (rx_id),
    .acc_code  (acc_code),
    .acc_mask  (acc_mask),
    .filter_en (filter_en),
    .accept    (accept)
  );

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign in_frame = '{id: rx_id, dlc: rx_dlc, data: rx_data};

  // A pop while full frees the slot this cycle, so the push still lands.
  assign pop      = re && !empty;
  assign push     = rx_valid && accept && (!full || re);
  assign overflow = rx_valid && accept && full && !re;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    if (pop) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // The new frame becomes head when it lands in a buffer that is (or becomes) empty;
  // its slot is only written at this edge, so bypass the array read.
  always_comb begin
    out_frame_next = mem[rd_ptr_next];
    if (push && (count_reg - CNT_W'(pop)) == '0) out_frame_next = in_frame;
    else if (count_next == '0)                   out_frame_next = '0;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_reg] <= in_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_frame_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_frame_reg <= out_frame_next;
    end
  end

  // An overflow in the same cycle as a clear restarts the tally at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (overflow) begin
      overrun_reg <= 1'b1;
      if (overrun_clr)              drop_cnt_reg <= DROP_W'(1);
      else if (drop_cnt_reg != '1)  drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end else if (overrun_clr) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  assign out_valid = !empty;
  assign out_id    = out_frame_reg.id;
  assign out_dlc   = out_frame_reg.dlc;
  assign out_data  = out_frame_reg.data;
  assign count     = count_reg;
  assign overrun   = overrun_reg;
  assign drop_cnt  = drop_cnt_reg;
endmodule

// File: tb/tb_can_rx_buffer.sv
// Self-checking bench for can_rx_buffer: vector table, directed corner sequences, random vs queue model.
module tb_can_rx_buffer;
  import can_defs::*;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0, rx_valid = 1'b0, filter_en = 1'b0, re = 1'b0, overrun_clr = 1'b0;
  logic [10:0]          rx_id = '0, acc_code = '0, acc_mask = '0;
  logic [3:0]           rx_dlc = '0;
  logic [7:0][7:0]      rx_data = '0;
  logic                 out_valid, full, empty, overrun;
  logic [10:0]          out_id;
  logic [3:0]           out_dlc;
  logic [7:0][7:0]      out_data;
  logic [3:0]           count;
  logic [DROP_W-1:0]    drop_cnt;

  can_rx_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_id(rx_id), .rx_dlc(rx_dlc),
    .rx_data(rx_data), .filter_en(filter_en), .acc_code(acc_code), .acc_mask(acc_mask),
    .re(re), .overrun_clr(overrun_clr), .out_valid(out_valid), .out_id(out_id),
    .out_dlc(out_dlc), .out_data(out_data), .count(count), .full(full), .empty(empty),
    .overrun(overrun), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of frames plus the overrun tally.
  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } mframe_t;

  mframe_t q[$];
  bit      m_ovr  = 0;
  int      m_drop = 0;

  function automatic bit model_accept();
    if (!filter_en) return 1;
    for (int b = 0; b < 11; b++)
      if (!acc_mask[b] && (rx_id[b] != acc_code[b])) return 0;
    return 1;
  endfunction

  // Apply the current inputs across one edge, advance the model, compare every output.
  task automatic step();
    mframe_t f;
    int      n;
    bit      lost;
    lost = 0;
    if (rst) begin
      q.delete(); m_ovr = 0; m_drop = 0;
    end else begin
      n = q.size();
      if (re && n > 0) void'(q.pop_front());
      if (rx_valid && model_accept()) begin
        if (n < DEPTH || re) begin
          f.id = rx_id; f.dlc = rx_dlc; f.data = rx_data;
          q.push_back(f);
        end else begin
          lost = 1; m_ovr = 1;
          m_drop = overrun_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end
      end
      if (overrun_clr && !lost) begin m_ovr = 0; m_drop = 0; end
    end
    @(posedge clk); #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_id", 64'(out_id), (q.size() != 0) ? 64'(q[0].id) : 64'd0);
    chk("out_dlc", 64'(out_dlc), (q.size() != 0) ? 64'(q[0].dlc) : 64'd0);
    chk("out_data", out_data, (q.size() != 0) ? q[0].data : 64'd0);
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic drive(input bit v, input logic [10:0] id, input logic [3:0] dlc,
                       input logic [63:0] data, input bit r, input bit c);
    rx_valid = v; rx_id = id; rx_dlc = dlc; rx_data = data; re = r; overrun_clr = c;
    step();
    rx_valid = 0; re = 0; overrun_clr = 0;
  endtask

  task automatic push_id(input logic [10:0] id, input bit r);
    drive(1, id, 4'($urandom_range(0, 15)), {$urandom, $urandom}, r, 0);
  endtask

  typedef struct {
    bit          v;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [15:0] data;
    bit          fen;
    logic [10:0] code;
    logic [10:0] mask;
    bit          r;
    int          e_count;
    logic [10:0] e_head;
    logic [15:0] e_data;
    bit          e_ovr;
  } vec_t;

  vec_t vecs[9];
  logic [10:0] last_id;

  initial begin
    vecs[0] = '{1, 11'h123, 4'd2, 16'hBBAA, 0, 11'h000, 11'h000, 0, 1, 11'h123, 16'hBBAA, 0};
    vecs[1] = '{0, 11'h000, 4'd0, 16'h0000, 0, 11'h000, 11'h000, 1, 0, 11'h000, 16'h0000, 0};
    vecs[2] = '{1, 11'h12A, 4'd8, 16'h1111, 1, 11'h120, 11'h00F, 0, 1, 11'h12A, 16'h1111, 0};
    vecs[3] = '{1, 11'h130, 4'd8, 16'h2222, 1, 11'h120, 11'h00F, 0, 1, 11'h12A, 16'h1111, 0};
    vecs[4] = '{0, 11'h000, 4'd0, 16'h0000, 1, 11'h120, 11'h00F, 1, 0, 11'h000, 16'h0000, 0};
    vecs[5] = '{0, 11'h000, 4'd0, 16'h0000, 0, 11'h000, 11'h000, 1, 0, 11'h000, 16'h0000, 0};
    vecs[6] = '{1, 11'h7FF, 4'd15, 16'h3333, 1, 11'h000, 11'h7FF, 0, 1, 11'h7FF, 16'h3333, 0};
    vecs[7] = '{1, 11'h001, 4'd1, 16'h4444, 1, 11'h001, 11'h000, 1, 1, 11'h001, 16'h4444, 0};
    vecs[8] = '{0, 11'h000, 4'd0, 16'h0000, 0, 11'h000, 11'h000, 1, 0, 11'h000, 16'h0000, 0};

    rst = 1; step(); rst = 0;
    chk("reset_empty", 64'(empty), 64'd1);

    foreach (vecs[i]) begin
      filter_en = vecs[i].fen; acc_code = vecs[i].code; acc_mask = vecs[i].mask;
      drive(vecs[i].v, vecs[i].id, vecs[i].dlc, {48'd0, vecs[i].data}, vecs[i].r, 0);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d_head", i), 64'(out_id), 64'(vecs[i].e_head));
      chk($sformatf("vec%0d_data", i), 64'(out_data[1:0]), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_ovr", i), 64'(overrun), 64'(vecs[i].e_ovr));
    end
    filter_en = 0;

    // Fill, overflow once, then drain in order.
    for (int i = 1; i <= 8; i++) push_id(11'(i), 0);
    push_id(11'h009, 0);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_overrun", 64'(overrun), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd1);
    chk("ovf_head", 64'(out_id), 64'h001);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 64'(out_id), 64'(i));
      drive(0, 0, 0, 0, 1, 0);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Push while popping a full buffer: no overrun, new frame lands at the tail.
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) push_id(11'h010 + 11'(i), 0);
    push_id(11'h0AA, 1);
    chk("wrap_count", 64'(count), 64'd8);
    chk("wrap_overrun", 64'(overrun), 64'd0);
    for (int i = 0; i < 8; i++) begin
      last_id = out_id;
      drive(0, 0, 0, 0, 1, 0);
    end
    chk("wrap_last", 64'(last_id), 64'h0AA);

    // Saturating drop counter and clear priority.
    for (int i = 0; i < 8; i++) push_id(11'h020 + 11'(i), 0);
    for (int i = 0; i < 300; i++) push_id(11'h300, 0);
    chk("sat_drop", 64'(drop_cnt), 64'hFF);
    drive(0, 0, 0, 0, 0, 1);
    chk("clr_overrun", 64'(overrun), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    drive(1, 11'h301, 4'd3, 64'd5, 0, 1);
    chk("clr_ovf_overrun", 64'(overrun), 64'd1);
    chk("clr_ovf_drop", 64'(drop_cnt), 64'd1);

    // Reset mid-stream with a frame strobed in the reset cycle.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 5; i++) push_id(11'h050 + 11'(i), 0);
    rst = 1; push_id(11'h05F, 0); rst = 0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_not_stored", 64'(count), 64'd0);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) begin
        filter_en = 1'($urandom);
        acc_code  = 11'($urandom);
        acc_mask  = 11'($urandom) | 11'h7C0;
      end
      rst         = ($urandom_range(0, 299) == 0);
      rx_valid    = ($urandom_range(0, 9) < 6);
      rx_id       = 11'($urandom);
      rx_dlc      = 4'($urandom);
      rx_data     = {$urandom, $urandom};
      re          = ($urandom_range(0, 9) < 4);
      overrun_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0; rx_valid = 0; re = 0; overrun_clr = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
